switch_nport_rr: RTL and testbench
==================================

Name: switch_nport_rr

Overview:
- Parametrised N-port packet switch, the successor to the fixed 4-port switch.
- Each ingress port has an input FIFO with valid/ready backpressure.
- Each egress port has a round-robin arbiter over the FIFO heads that target it, and a registered output stage.
- Sits between the port interfaces and the packet sources/sinks. Unknown targets are dropped and counted.

Parameters:
- NUM_PORTS, 4, number of ports (2..16).
- DATA_W, 8, payload width.
- FIFO_DEPTH, 4, entries per ingress FIFO (power of 2, ≥2).
- PORT_W (localparam), $clog2(NUM_PORTS), width of source/target fields.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  NUM_PORTS  per-port ingress valid.
- ready_in  out  NUM_PORTS  per-port ingress ready; equals !fifo_full.
- source_in  in  NUM_PORTS*PORT_W  per-port source id.
- target_in  in  NUM_PORTS*PORT_W  per-port destination id.
- data_in  in  NUM_PORTS*DATA_W  per-port payload.
- valid_out  out  NUM_PORTS  per-port egress valid, one-cycle pulse per packet.
- source_out  out  NUM_PORTS*PORT_W  egress source id.
- target_out  out  NUM_PORTS*PORT_W  egress target id; always equals the port index.
- data_out  out  NUM_PORTS*DATA_W  egress payload.
- drop_cnt  out  16  saturating count of packets with target ≥ NUM_PORTS.

Behaviour:
- Reset: asynchronous on rst_n low. Effects:
  - all FIFOs emptied and arbiter pointers set to 0;
  - valid_out, source_out, target_out, data_out and drop_cnt driven to 0;
  - ready_in all 1 once rst_n is high.
- Reset mid-operation discards all queued packets. No partial outputs.

Ingress:
- A packet is accepted on a rising edge when valid_in[i] && ready_in[i]. The sender holds its fields while valid && !ready.
- ready_in[i] = (count_i != FIFO_DEPTH), taken from registered state. A push on a full FIFO is not permitted even if a pop occurs in the same cycle.
- If target_in ≥ NUM_PORTS (only possible for non-power-of-2 NUM_PORTS), the packet is accepted, not enqueued, and drop_cnt increments, saturating at 0xFFFF.

Arbitration:
- Evaluated combinationally each cycle per egress port j.
- Requesters are the non-empty FIFOs whose head target == j.
- Priority starts at ptr_j and rotates upward mod NUM_PORTS.
- On a grant to input i: FIFO i pops and ptr_j <= (i+1) mod NUM_PORTS. With no request, ptr_j holds.
- Each head targets exactly one egress port, so at most one grant per input per cycle.
- Loopback (target == source port) is allowed.

Egress:
- Registered. Each cycle: valid_out[j] <= any_grant_j, and the granted head's source/target/data are loaded.
- When valid_out[j] is 0, data fields hold their last value.
- There is no egress backpressure; the sink always accepts.

Latency and throughput:
- A packet accepted at edge t into an empty FIFO with no contention appears on valid_out at edge t+1 (visible in the cycle after t+1).
- Per-port throughput is 1 packet/cycle.
- Simultaneous push and pop on a non-full FIFO leaves count unchanged. FIFO read/write pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package switch_pkg holds:
  - the default constants DEF_NUM_PORTS, DEF_DATA_W, DEF_FIFO_DEPTH;
  - function rr_pick(req, ptr), returning a one-hot grant.
- The packet struct {source, target, data} is declared locally from the parameters.
- Sub-module: switch_fifo (parametrised synchronous FIFO, WIDTH/DEPTH; push, pop, full, empty, head). Instantiated NUM_PORTS times in a generate loop.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release → ready_in=4'b1111, valid_out=0, drop_cnt=0.
- Single packet, port0 → target 2, data 8'hA5, accepted at edge t → valid_out[2]=1 for exactly one cycle after edge t+1, source_out[2]=0, data_out[2]=A5; all other valid_out stay 0.
- Contention, ports 0,1,3 all → target 1 in the same cycle with data 11,22,33 → out1 emits 11, 22, 33 on consecutive cycles. Repeat immediately: grants start from port 0 again because ptr=0 after port 3's grant (3+1 mod 4=0); starting from port 1 here indicates a bug.
- Backpressure, FIFO_DEPTH=4, port0 floods target 3 while port1 also saturates target 3 → ready_in[0] drops after 4 queued; no packet lost or duplicated; out3 alternates port0/port1.
- Bad target, NUM_PORTS=3, target_in=3 on port2 → accepted (ready stays 1), no valid_out, drop_cnt=1; then 70000 such packets → drop_cnt=16'hFFFF.
- Reset mid-traffic: FIFOs half full, rst_n pulse low asynchronously between edges → outputs 0 immediately; after release no stale packets emerge.

Source files
------------

// File: rtl/switch_nport_rr_pkg.sv
`default_nettype none
// ============================================================================
// switch_pkg : shared defaults and the round-robin pick helper for the switch
// Revision   : 1.0
// ============================================================================
package switch_pkg;

   localparam int DEF_NUM_PORTS  = 4;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int MAX_PORTS      = 16;
   localparam int MAX_PW         = 4;

   // Scans upward from ptr and wraps mod 16; request bits at or above the
   // real port count are always zero, so this is equivalent to wrapping mod N.
   function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                    input logic [MAX_PW-1:0]    ptr);
      logic [MAX_PORTS-1:0] gnt;
      logic                 found;
      logic [MAX_PW-1:0]    idx;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_PORTS; k++) begin
         idx = ptr + MAX_PW'(k);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/switch_nport_rr_if.sv
`default_nettype none
// ============================================================================
// switch_nport_rr_if : ingress/egress bundle of the N-port switch
// Revision           : 1.0
// ============================================================================
interface switch_nport_rr_if
   import switch_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int DATA_W    = DEF_DATA_W
);
   localparam int PORT_W = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0]        valid_in;
   logic [NUM_PORTS-1:0]        ready_in;
   logic [NUM_PORTS*PORT_W-1:0] source_in;
   logic [NUM_PORTS*PORT_W-1:0] target_in;
   logic [NUM_PORTS*DATA_W-1:0] data_in;
   logic [NUM_PORTS-1:0]        valid_out;
   logic [NUM_PORTS*PORT_W-1:0] source_out;
   logic [NUM_PORTS*PORT_W-1:0] target_out;
   logic [NUM_PORTS*DATA_W-1:0] data_out;
   logic [15:0]                 drop_cnt;

   modport master (
      output valid_in, source_in, target_in, data_in,
      input  ready_in, valid_out, source_out, target_out, data_out, drop_cnt
   );

   modport slave (
      input  valid_in, source_in, target_in, data_in,
      output ready_in, valid_out, source_out, target_out, data_out, drop_cnt
   );

endinterface
`default_nettype wire

// File: rtl/switch_nport_rr_fifo.sv
`default_nettype none
// ============================================================================
// switch_fifo : synchronous FIFO, power-of-2 depth, head visible when non-empty
// Revision    : 1.0
// ============================================================================
module switch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             push,
   input  wire logic             pop,
   input  wire logic [WIDTH-1:0] wdata,
   output logic                  full,
   output logic                  empty,
   output logic      [WIDTH-1:0] head
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Fullness comes from registered count only: a pop never frees a slot
   // for a push in the same cycle.
   assign full   = (r_count == CW'(DEPTH));
   assign empty  = (r_count == '0);
   assign head   = r_mem[r_rd];
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/switch_nport_rr.sv
`default_nettype none
// ============================================================================
// switch_nport_rr : N-port packet switch, ingress FIFOs, per-egress RR arbiter
// Revision        : 1.0
// ============================================================================
module switch_nport_rr
   import switch_pkg::*;
#(
   parameter int NUM_PORTS  = DEF_NUM_PORTS,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input wire logic         clk,
   input wire logic         rst_n,
   switch_nport_rr_if.slave bus
);
   localparam int PORT_W = $clog2(NUM_PORTS);
   localparam int CNT_W  = $clog2(NUM_PORTS + 1);
   localparam logic [PORT_W:0] c_num_ports = (PORT_W+1)'(NUM_PORTS);

   typedef struct packed {
      logic [PORT_W-1:0] source;
      logic [PORT_W-1:0] target;
      logic [DATA_W-1:0] data;
   } pkt_t;
   localparam int PKT_W = $bits(pkt_t);

   pkt_t                  w_in_pkt [NUM_PORTS];
   pkt_t                  w_head   [NUM_PORTS];
   pkt_t                  w_sel    [NUM_PORTS];
   pkt_t                  r_out    [NUM_PORTS];
   logic [NUM_PORTS-1:0]  w_gnt    [NUM_PORTS];
   logic [PORT_W-1:0]     r_ptr    [NUM_PORTS];
   logic [PORT_W-1:0]     w_ptr_nxt[NUM_PORTS];
   logic [NUM_PORTS-1:0]  w_full, w_empty, w_bad, w_accept, w_push, w_pop;
   logic [NUM_PORTS-1:0]  w_any_gnt;
   logic [NUM_PORTS-1:0]  r_valid;
   logic [MAX_PORTS-1:0]  w_req16, w_gnt16;
   logic [15:0]           r_drop, w_drop_nxt;
   logic [16:0]           w_drop_sum;
   logic [CNT_W-1:0]      w_drop_inc;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign w_in_pkt[i] = {bus.source_in[i*PORT_W +: PORT_W],
                            bus.target_in[i*PORT_W +: PORT_W],
                            bus.data_in[i*DATA_W +: DATA_W]};
      // Out-of-range targets are still handshaken, just never enqueued.
      assign w_bad[i]    = ({1'b0, w_in_pkt[i].target} >= c_num_ports);
      assign w_accept[i] = bus.valid_in[i] & ~w_full[i];
      assign w_push[i]   = w_accept[i] & ~w_bad[i];

      switch_fifo #(
         .WIDTH(PKT_W),
         .DEPTH(FIFO_DEPTH)
      ) u_fifo (
         .clk  (clk),
         .rst_n(rst_n),
         .push (w_push[i]),
         .pop  (w_pop[i]),
         .wdata(w_in_pkt[i]),
         .full (w_full[i]),
         .empty(w_empty[i]),
         .head (w_head[i])
      );

      assign bus.source_out[i*PORT_W +: PORT_W] = r_out[i].source;
      assign bus.target_out[i*PORT_W +: PORT_W] = r_out[i].target;
      assign bus.data_out[i*DATA_W +: DATA_W]   = r_out[i].data;
   end

   assign bus.ready_in  = ~w_full;
   assign bus.valid_out = r_valid;
   assign bus.drop_cnt  = r_drop;

   always_comb begin
      w_pop     = '0;
      w_any_gnt = '0;
      w_req16   = '0;
      w_gnt16   = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         w_req16 = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            w_req16[i] = ~w_empty[i] && (w_head[i].target == PORT_W'(j));
         end
         w_gnt16      = rr_pick(w_req16, MAX_PW'(r_ptr[j]));
         w_gnt[j]     = w_gnt16[NUM_PORTS-1:0];
         w_any_gnt[j] = |w_gnt[j];
         w_pop        = w_pop | w_gnt[j];
         w_ptr_nxt[j] = r_ptr[j];
         w_sel[j]     = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt[j][i]) begin
               w_ptr_nxt[j] = (i == NUM_PORTS-1) ? '0 : PORT_W'(i + 1);
               w_sel[j]     = w_head[i];
            end
         end
      end
   end

   // Several ports may drop in the same cycle, so add the whole batch.
   always_comb begin
      w_drop_inc = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_drop_inc = w_drop_inc + CNT_W'(w_accept[i] & w_bad[i]);
      end
      w_drop_sum = {1'b0, r_drop} + 17'(w_drop_inc);
      w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_drop  <= '0;
         for (int j = 0; j < NUM_PORTS; j++) begin
            r_ptr[j] <= '0;
            r_out[j] <= '0;
         end
      end else begin
         r_valid <= w_any_gnt;
         r_drop  <= w_drop_nxt;
         for (int j = 0; j < NUM_PORTS; j++) begin
            r_ptr[j] <= w_ptr_nxt[j];
            if (w_any_gnt[j]) r_out[j] <= w_sel[j];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_switch_nport_rr.sv
`default_nettype none
// ============================================================================
// tb_switch_nport_rr : directed self-checking bench (4-port and 3-port builds)
// Revision           : 1.0
// ============================================================================
module tb_switch_nport_rr;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   switch_nport_rr_if #(.NUM_PORTS(4), .DATA_W(8)) bus_a ();
   switch_nport_rr_if #(.NUM_PORTS(3), .DATA_W(8)) bus_b ();

   switch_nport_rr #(.NUM_PORTS(4), .DATA_W(8), .FIFO_DEPTH(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   switch_nport_rr #(.NUM_PORTS(3), .DATA_W(8), .FIFO_DEPTH(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   typedef struct {int cyc; int port; int src; int tgt; int data;} mon_t;
   typedef struct {int port; int src; int tgt; int data;} tx_t;

   mon_t monq[$];
   tx_t  txq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   b_vout = 0;
   bit   ready0_low = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int j = 0; j < 4; j++) begin
         if (bus_a.valid_out[j])
            monq.push_back('{cyc, j, int'(bus_a.source_out[j*2 +: 2]),
                             int'(bus_a.target_out[j*2 +: 2]), int'(bus_a.data_out[j*8 +: 8])});
      end
      if (|bus_b.valid_out) b_vout++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add_tx(input int port, input int src, input int tgt, input int data);
      txq.push_back('{port, src, tgt, data});
   endtask

   // Drives the oldest pending packet of every port each cycle, holding it until accepted.
   task automatic run_traffic(output int last_acc);
      int        guard;
      int        idx [4];
      logic [3:0] rdy;
      tx_t       keep[$];
      guard    = 0;
      last_acc = 0;
      while (txq.size() > 0 && guard < 300) begin
         guard++;
         @(negedge clk);
         bus_a.valid_in = '0;
         for (int p = 0; p < 4; p++) idx[p] = -1;
         for (int k = 0; k < txq.size(); k++) begin
            if (idx[txq[k].port] < 0) begin
               idx[txq[k].port] = k;
               bus_a.valid_in[txq[k].port]               = 1'b1;
               bus_a.source_in[txq[k].port*2 +: 2]       = 2'(txq[k].src);
               bus_a.target_in[txq[k].port*2 +: 2]       = 2'(txq[k].tgt);
               bus_a.data_in[txq[k].port*8 +: 8]         = 8'(txq[k].data);
            end
         end
         rdy = bus_a.ready_in;
         if (bus_a.valid_in[0] && !rdy[0]) ready0_low = 1'b1;
         @(posedge clk);
         #1;
         keep.delete();
         for (int k = 0; k < txq.size(); k++) begin
            if (idx[txq[k].port] == k && rdy[txq[k].port]) last_acc = cyc;
            else keep.push_back(txq[k]);
         end
         txq = keep;
      end
      bus_a.valid_in = '0;
      check_eq("tx_drain", txq.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int exp_d [6] = '{'h11, 'h22, 'h33, 'h11, 'h22, 'h33};
      int exp_s [6] = '{0, 1, 3, 0, 1, 3};

      bus_a.valid_in = '0; bus_a.source_in = '0; bus_a.target_in = '0; bus_a.data_in = '0;
      bus_b.valid_in = '0; bus_b.source_in = '0; bus_b.target_in = '0; bus_b.data_in = '0;

      // Reset then idle
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_ready_a", bus_a.ready_in, 4'b1111);
      check_eq("rst_valid_a", bus_a.valid_out, 4'b0000);
      check_eq("rst_drop_a", bus_a.drop_cnt, 16'h0);
      check_eq("rst_data_a", bus_a.data_out, 32'h0);
      check_eq("rst_ready_b", bus_b.ready_in, 3'b111);
      check_eq("rst_drop_b", bus_b.drop_cnt, 16'h0);

      // Single packet port0 -> egress 2
      monq.delete();
      add_tx(0, 0, 2, 'hA5);
      run_traffic(acc);
      repeat (5) @(negedge clk);
      check_eq("single_count", monq.size(), 1);
      if (monq.size() >= 1) begin
         check_eq("single_port", monq[0].port, 2);
         check_eq("single_src", monq[0].src, 0);
         check_eq("single_tgt", monq[0].tgt, 2);
         check_eq("single_data", monq[0].data, 'hA5);
         check_eq("single_lat", monq[0].cyc, acc + 1);
      end

      // Contention on egress 1, two back-to-back rounds
      monq.delete();
      for (int r = 0; r < 2; r++) begin
         add_tx(0, 0, 1, 'h11);
         add_tx(1, 1, 1, 'h22);
         add_tx(3, 3, 1, 'h33);
      end
      run_traffic(acc);
      repeat (10) @(negedge clk);
      check_eq("cont_count", monq.size(), 6);
      for (int k = 0; k < 6 && k < monq.size(); k++) begin
         check_eq($sformatf("cont_port%0d", k), monq[k].port, 1);
         check_eq($sformatf("cont_data%0d", k), monq[k].data, exp_d[k]);
         check_eq($sformatf("cont_src%0d", k), monq[k].src, exp_s[k]);
         check_eq($sformatf("cont_cyc%0d", k), monq[k].cyc, acc + k);
      end

      // Backpressure: ports 0 and 1 both saturate egress 3
      monq.delete();
      ready0_low = 1'b0;
      for (int k = 0; k < 8; k++) begin
         add_tx(0, 0, 3, k);
         add_tx(1, 1, 3, 'h80 + k);
      end
      run_traffic(acc);
      repeat (30) @(negedge clk);
      check_eq("bp_ready0_low", ready0_low, 1'b1);
      check_eq("bp_count", monq.size(), 16);
      for (int k = 0; k < 16 && k < monq.size(); k++) begin
         check_eq($sformatf("bp_port%0d", k), monq[k].port, 3);
         check_eq($sformatf("bp_src%0d", k), monq[k].src, k % 2);
         check_eq($sformatf("bp_data%0d", k), monq[k].data, ((k % 2) ? 'h80 : 'h00) + k / 2);
      end
      check_eq("bp_drop_a", bus_a.drop_cnt, 16'h0);

      // Bad target on the 3-port build
      @(negedge clk);
      bus_b.valid_in  = 3'b100;
      bus_b.target_in = 6'b11_00_00;
      check_eq("bad_ready", bus_b.ready_in[2], 1'b1);
      @(negedge clk);
      bus_b.valid_in = '0;
      check_eq("bad_drop1", bus_b.drop_cnt, 16'd1);
      bus_b.valid_in  = 3'b111;
      bus_b.target_in = 6'b11_11_11;
      repeat (1000) @(posedge clk);
      @(negedge clk);
      check_eq("bad_drop3001", bus_b.drop_cnt, 16'd3001);
      repeat (22334) @(posedge clk);
      @(negedge clk);
      bus_b.valid_in = '0;
      check_eq("bad_drop_sat", bus_b.drop_cnt, 16'hFFFF);
      check_eq("bad_ready_all", bus_b.ready_in, 3'b111);
      @(negedge clk);
      check_eq("bad_no_valid", b_vout, 0);
      check_eq("bad_drop_hold", bus_b.drop_cnt, 16'hFFFF);

      // Reset in the middle of heavy contention on egress 0
      for (int p = 0; p < 4; p++)
         for (int k = 0; k < 3; k++) add_tx(p, p, 0, p * 16 + k);
      run_traffic(acc);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", bus_a.valid_out, 4'b0000);
      check_eq("mid_rst_data", bus_a.data_out, 32'h0);
      check_eq("mid_rst_src", bus_a.source_out, 8'h0);
      check_eq("mid_rst_drop_b", bus_b.drop_cnt, 16'h0);
      #2 rst_n = 1'b1;
      monq.delete();
      repeat (20) @(negedge clk);
      check_eq("mid_rst_stale", monq.size(), 0);
      check_eq("mid_rst_ready", bus_a.ready_in, 4'b1111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
